// File: rtl/tdp_ram36k_pkg.sv
// rtl/tdp_ram36k_pkg.sv - geometry constants and width decode helpers for the 36Kb true dual-port RAM
package tdp_ram36k_pkg;

    localparam int ROWS      = 1024;
    localparam int DATA_BITS = 32;
    localparam int PAR_BITS  = 4;
    localparam int ROW_BITS  = 10;
    localparam int ADDR_BITS = 15;

    typedef struct packed {
        logic [5:0] data_bits;
        logic [2:0] par_bits;
        logic [2:0] sel_bits;
    } width_cfg_t;

    // sel_bits is how many of ADDR[4:0] pick the field inside a row
    function automatic width_cfg_t width_cfg(input int width);
        width_cfg_t cfg;
        case (width)
            36:      cfg = '{data_bits: 6'd32, par_bits: 3'd4, sel_bits: 3'd0};
            18:      cfg = '{data_bits: 6'd16, par_bits: 3'd2, sel_bits: 3'd1};
            9:       cfg = '{data_bits: 6'd8,  par_bits: 3'd1, sel_bits: 3'd2};
            4:       cfg = '{data_bits: 6'd4,  par_bits: 3'd0, sel_bits: 3'd3};
            2:       cfg = '{data_bits: 6'd2,  par_bits: 3'd0, sel_bits: 3'd4};
            1:       cfg = '{data_bits: 6'd1,  par_bits: 3'd0, sel_bits: 3'd5};
            default: cfg = '{data_bits: 6'd32, par_bits: 3'd4, sel_bits: 3'd0};
        endcase
        return cfg;
    endfunction

    function automatic bit width_legal(input int width);
        return width inside {1, 2, 4, 9, 18, 36};
    endfunction

endpackage

// File: rtl/tdp_ram36k_port.sv
// rtl/tdp_ram36k_port.sv - one RAM port: address decode, write mask/value build, read extract and output register
module tdp_ram36k_port
    import tdp_ram36k_pkg::*;
#(
    parameter int WRITE_WIDTH = 36,
    parameter int READ_WIDTH  = 36
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [3:0]            be,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_BITS-1:0]  wdata,
    input  logic [PAR_BITS-1:0]   wparity,
    input  logic [DATA_BITS-1:0]  row_data,
    input  logic [PAR_BITS-1:0]   row_par,
    output logic [ROW_BITS-1:0]   row,
    output logic                  we,
    output logic [DATA_BITS-1:0]  wmask_data,
    output logic [DATA_BITS-1:0]  wval_data,
    output logic [PAR_BITS-1:0]   wmask_par,
    output logic [PAR_BITS-1:0]   wval_par,
    output logic [DATA_BITS-1:0]  rdata,
    output logic [PAR_BITS-1:0]   rparity
);

    localparam width_cfg_t WCFG = width_cfg(WRITE_WIDTH);
    localparam width_cfg_t RCFG = width_cfg(READ_WIDTH);
    localparam int W_K = int'(WCFG.data_bits);
    localparam int W_P = int'(WCFG.par_bits);
    localparam int W_S = int'(WCFG.sel_bits);
    localparam int R_K = int'(RCFG.data_bits);
    localparam int R_P = int'(RCFG.par_bits);
    localparam int R_S = int'(RCFG.sel_bits);
    localparam bit W_BYTE_BE = (WRITE_WIDTH >= 18);

    localparam logic [DATA_BITS-1:0] W_KMASK = 32'hFFFF_FFFF >> (32 - W_K);
    localparam logic [DATA_BITS-1:0] R_KMASK = 32'hFFFF_FFFF >> (32 - R_K);
    localparam logic [PAR_BITS-1:0]  W_PMASK = 4'hF >> (4 - W_P);
    localparam logic [PAR_BITS-1:0]  R_PMASK = 4'hF >> (4 - R_P);
    // keeps only the address bits that select a field, which is also its bit offset
    localparam logic [4:0] W_OFF_MASK = 5'(32'h1F << (5 - W_S));
    localparam logic [4:0] R_OFF_MASK = 5'(32'h1F << (5 - R_S));

    if (!width_legal(WRITE_WIDTH) || !width_legal(READ_WIDTH)) begin : g_bad_width
        $fatal(1, "%m: illegal width parameter (write %0d, read %0d)", WRITE_WIDTH, READ_WIDTH);
    end

    logic [4:0]           bit_sel;
    logic [4:0]           w_off;
    logic [4:0]           r_off;
    logic [1:0]           w_poff;
    logic [1:0]           r_poff;
    logic [DATA_BITS-1:0] be_data;
    logic [PAR_BITS-1:0]  be_par;
    logic [DATA_BITS-1:0] rdata_q = '0;
    logic [PAR_BITS-1:0]  rparity_q = '0;

    assign row     = addr[ADDR_BITS-1:5];
    assign bit_sel = addr[4:0];
    assign w_off   = bit_sel & W_OFF_MASK;
    assign r_off   = bit_sel & R_OFF_MASK;
    assign w_poff  = 2'((32'(bit_sel) >> (5 - W_S)) * W_P);
    assign r_poff  = 2'((32'(bit_sel) >> (5 - R_S)) * R_P);

    assign be_data = W_BYTE_BE ? {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}} : {32{be[0]}};
    assign be_par  = W_BYTE_BE ? be : {4{be[0]}};

    assign we         = wen & ~reset;
    assign wmask_data = (W_KMASK & be_data) << w_off;
    assign wval_data  = (wdata & W_KMASK) << w_off;
    assign wmask_par  = (W_PMASK & be_par) << w_poff;
    assign wval_par   = (wparity & W_PMASK) << w_poff;

    // row_data is the pre-edge contents, so a coincident write is never seen here
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q   <= '0;
            rparity_q <= '0;
        end else if (ren) begin
            rdata_q   <= (row_data >> r_off) & R_KMASK;
            rparity_q <= (row_par >> r_poff) & R_PMASK;
        end
    end

    assign rdata   = rdata_q;
    assign rparity = rparity_q;

endmodule

// File: rtl/tdp_ram36k.sv
// rtl/tdp_ram36k.sv - 36Kb true dual-port RAM with per-port aspect ratios around one shared array
// Optional TDP_RAM36K_COLLISION_CHECK_EN reports overlapping same-row writes from both ports.
module tdp_ram36k
    import tdp_ram36k_pkg::*;
#(
    parameter logic [ROWS*DATA_BITS-1:0] INIT        = '0,
    parameter logic [ROWS*PAR_BITS-1:0]  INIT_PARITY = '0,
    parameter int WRITE_WIDTH_A = 36,
    parameter int READ_WIDTH_A  = 36,
    parameter int WRITE_WIDTH_B = 36,
    parameter int READ_WIDTH_B  = 36
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 WEN_A,
    input  logic                 REN_A,
    input  logic [3:0]           BE_A,
    input  logic [ADDR_BITS-1:0] ADDR_A,
    input  logic [DATA_BITS-1:0] WDATA_A,
    input  logic [PAR_BITS-1:0]  WPARITY_A,
    output logic [DATA_BITS-1:0] RDATA_A,
    output logic [PAR_BITS-1:0]  RPARITY_A,
    input  logic                 WEN_B,
    input  logic                 REN_B,
    input  logic [3:0]           BE_B,
    input  logic [ADDR_BITS-1:0] ADDR_B,
    input  logic [DATA_BITS-1:0] WDATA_B,
    input  logic [PAR_BITS-1:0]  WPARITY_B,
    output logic [DATA_BITS-1:0] RDATA_B,
    output logic [PAR_BITS-1:0]  RPARITY_B
);

    logic [ROWS*DATA_BITS-1:0] mem_data = INIT;
    logic [ROWS*PAR_BITS-1:0]  mem_par  = INIT_PARITY;

    logic [ROW_BITS-1:0]  row_a, row_b;
    logic                 we_a, we_b;
    logic [DATA_BITS-1:0] wmask_data_a, wval_data_a, wmask_data_b, wval_data_b;
    logic [PAR_BITS-1:0]  wmask_par_a, wval_par_a, wmask_par_b, wval_par_b;
    logic [DATA_BITS-1:0] old_data_a, old_data_b, new_data_a, new_data_b, base_data_a;
    logic [PAR_BITS-1:0]  old_par_a, old_par_b, new_par_a, new_par_b, base_par_a;
    logic                 same_row;

    assign old_data_a = mem_data[{row_a, 5'd0} +: DATA_BITS];
    assign old_data_b = mem_data[{row_b, 5'd0} +: DATA_BITS];
    assign old_par_a  = mem_par[{row_a, 2'd0} +: PAR_BITS];
    assign old_par_b  = mem_par[{row_b, 2'd0} +: PAR_BITS];

    tdp_ram36k_port #(
        .WRITE_WIDTH (WRITE_WIDTH_A),
        .READ_WIDTH  (READ_WIDTH_A)
    ) u_port_a (
        .clk        (CLK),
        .reset      (RESET),
        .wen        (WEN_A),
        .ren        (REN_A),
        .be         (BE_A),
        .addr       (ADDR_A),
        .wdata      (WDATA_A),
        .wparity    (WPARITY_A),
        .row_data   (old_data_a),
        .row_par    (old_par_a),
        .row        (row_a),
        .we         (we_a),
        .wmask_data (wmask_data_a),
        .wval_data  (wval_data_a),
        .wmask_par  (wmask_par_a),
        .wval_par   (wval_par_a),
        .rdata      (RDATA_A),
        .rparity    (RPARITY_A)
    );

    tdp_ram36k_port #(
        .WRITE_WIDTH (WRITE_WIDTH_B),
        .READ_WIDTH  (READ_WIDTH_B)
    ) u_port_b (
        .clk        (CLK),
        .reset      (RESET),
        .wen        (WEN_B),
        .ren        (REN_B),
        .be         (BE_B),
        .addr       (ADDR_B),
        .wdata      (WDATA_B),
        .wparity    (WPARITY_B),
        .row_data   (old_data_b),
        .row_par    (old_par_b),
        .row        (row_b),
        .we         (we_b),
        .wmask_data (wmask_data_b),
        .wval_data  (wval_data_b),
        .wmask_par  (wmask_par_b),
        .wval_par   (wval_par_b),
        .rdata      (RDATA_B),
        .rparity    (RPARITY_B)
    );

    assign same_row = (row_a == row_b);

    // B merges first; on a shared row A layers on top of B's result so A wins only where they overlap
    assign new_data_b  = (old_data_b & ~wmask_data_b) | (wval_data_b & wmask_data_b);
    assign new_par_b   = (old_par_b & ~wmask_par_b) | (wval_par_b & wmask_par_b);
    assign base_data_a = (we_b && same_row) ? new_data_b : old_data_a;
    assign base_par_a  = (we_b && same_row) ? new_par_b : old_par_a;
    assign new_data_a  = (base_data_a & ~wmask_data_a) | (wval_data_a & wmask_data_a);
    assign new_par_a   = (base_par_a & ~wmask_par_a) | (wval_par_a & wmask_par_a);

    always_ff @(posedge CLK) begin
        if (we_b && !(we_a && same_row)) begin
            mem_data[{row_b, 5'd0} +: DATA_BITS] <= new_data_b;
            mem_par[{row_b, 2'd0} +: PAR_BITS]   <= new_par_b;
        end
        if (we_a) begin
            mem_data[{row_a, 5'd0} +: DATA_BITS] <= new_data_a;
            mem_par[{row_a, 2'd0} +: PAR_BITS]   <= new_par_a;
        end
    end

`ifdef TDP_RAM36K_COLLISION_CHECK_EN
    always_ff @(posedge CLK) begin
        if (we_a && we_b && same_row &&
            (((wmask_data_a & wmask_data_b) != '0) || ((wmask_par_a & wmask_par_b) != '0))) begin
            $display("collision", $time, row_a);
        end
    end
`else
`endif

endmodule

// File: tb/tb_tdp_ram36k.sv
// tb/tb_tdp_ram36k.sv - scoreboard bench for tdp_ram36k: a 36/36 instance and a mixed-width instance
module tb_tdp_ram36k;

    // port index: 0 = main A, 1 = main B, 2 = mixed A, 3 = mixed B
    localparam logic [32767:0] TB_INIT     = 32768'(32'hCAFE_F00D) << 224;
    localparam logic [2047:0]  TB_INIT_PAR = 2048'(4'h9) << 28;

    typedef struct {
        string        tag;
        logic [35:0]  v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wen [4];
    logic        ren [4];
    logic [3:0]  be [4];
    logic [14:0] addr [4];
    logic [31:0] wdata [4];
    logic [3:0]  wpar [4];
    logic [31:0] rdata [4];
    logic [3:0]  rpar [4];

    exp_t sb [4][$];
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    tdp_ram36k #(
        .INIT (TB_INIT), .INIT_PARITY (TB_INIT_PAR),
        .WRITE_WIDTH_A (36), .READ_WIDTH_A (36), .WRITE_WIDTH_B (36), .READ_WIDTH_B (36)
    ) u_dut (
        .CLK (clk), .RESET (reset),
        .WEN_A (wen[0]), .REN_A (ren[0]), .BE_A (be[0]), .ADDR_A (addr[0]),
        .WDATA_A (wdata[0]), .WPARITY_A (wpar[0]), .RDATA_A (rdata[0]), .RPARITY_A (rpar[0]),
        .WEN_B (wen[1]), .REN_B (ren[1]), .BE_B (be[1]), .ADDR_B (addr[1]),
        .WDATA_B (wdata[1]), .WPARITY_B (wpar[1]), .RDATA_B (rdata[1]), .RPARITY_B (rpar[1])
    );

    tdp_ram36k #(
        .WRITE_WIDTH_A (36), .READ_WIDTH_A (18), .WRITE_WIDTH_B (9), .READ_WIDTH_B (9)
    ) u_dut_mix (
        .CLK (clk), .RESET (reset),
        .WEN_A (wen[2]), .REN_A (ren[2]), .BE_A (be[2]), .ADDR_A (addr[2]),
        .WDATA_A (wdata[2]), .WPARITY_A (wpar[2]), .RDATA_A (rdata[2]), .RPARITY_A (rpar[2]),
        .WEN_B (wen[3]), .REN_B (ren[3]), .BE_B (be[3]), .ADDR_B (addr[3]),
        .WDATA_B (wdata[3]), .WPARITY_B (wpar[3]), .RDATA_B (rdata[3]), .RPARITY_B (rpar[3])
    );

    task automatic check_eq(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic idle_all();
        for (int p = 0; p < 4; p++) begin
            wen[p] = 1'b0; ren[p] = 1'b0; be[p] = 4'h0;
            addr[p] = '0; wdata[p] = '0; wpar[p] = '0;
        end
    endtask

    task automatic wr(input int p, input logic [14:0] a, input logic [31:0] d,
                      input logic [3:0] par, input logic [3:0] b);
        wen[p] = 1'b1; addr[p] = a; wdata[p] = d; wpar[p] = par; be[p] = b;
    endtask

    task automatic rd(input int p, input logic [14:0] a, input string tag,
                      input logic [31:0] d, input logic [3:0] par);
        exp_t e;
        ren[p] = 1'b1; addr[p] = a;
        e.tag = tag; e.v = {par, d};
        sb[p].push_back(e);
    endtask

    // one clock; every port that issued a read compares against the oldest expectation
    task automatic tick();
        bit   pend [4];
        exp_t e;
        for (int p = 0; p < 4; p++) pend[p] = ren[p] && !reset;
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (pend[p]) begin
                if (sb[p].size() == 0) begin
                    check_eq("sb_underflow", 36'(sb[p].size()), 36'd1);
                end else begin
                    e = sb[p].pop_front();
                    check_eq(e.tag, {rpar[p], rdata[p]}, e.v);
                end
            end
        end
        idle_all();
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        reset = 1'b1;
        tick();
        tick();
        for (int p = 0; p < 4; p++) check_eq("reset_out", {rpar[p], rdata[p]}, 36'h0);
        reset = 1'b0;

        wr(0, 15'h0020, 32'h1234_5678, 4'hA, 4'hF);
        tick();
        rd(1, 15'h0020, "b_read_row1", 32'h1234_5678, 4'hA);
        tick();

        wr(0, 15'h0040, 32'hFFFF_FFFF, 4'hF, 4'b0010);
        tick();
        rd(0, 15'h0040, "a_be_byte1", 32'h0000_FF00, 4'h2);
        tick();

        wr(0, 15'h0060, 32'h5, 4'h0, 4'hF);
        tick();
        wr(0, 15'h0060, 32'h1, 4'h0, 4'hF);
        rd(1, 15'h0060, "b_cross_old", 32'h5, 4'h0);
        tick();
        rd(1, 15'h0060, "b_cross_new", 32'h1, 4'h0);
        tick();
        wr(0, 15'h0060, 32'h7, 4'h0, 4'hF);
        rd(0, 15'h0060, "a_read_first", 32'h1, 4'h0);
        tick();
        rd(0, 15'h0060, "a_after_write", 32'h7, 4'h0);
        tick();

        wr(0, 15'h0080, 32'hAAAA_AAAA, 4'h0, 4'hF);
        wr(1, 15'h0080, 32'h5555_5555, 4'hF, 4'hF);
        tick();
        rd(0, 15'h0080, "collide_a_wins", 32'hAAAA_AAAA, 4'h0);
        tick();
        wr(0, 15'h00A0, 32'h0000_00AA, 4'h0, 4'b0001);
        wr(1, 15'h00A0, 32'h5555_5555, 4'hF, 4'b1110);
        tick();
        rd(1, 15'h00A0, "collide_merge", 32'h5555_55AA, 4'hE);
        tick();

        rd(1, 15'h00E0, "b_init_row7", 32'hCAFE_F00D, 4'h9);
        tick();

        rd(0, 15'h0020, "a_pre_reset", 32'h1234_5678, 4'hA);
        tick();
        reset = 1'b1;
        ren[0] = 1'b1;
        wr(0, 15'h0020, 32'hDEAD_BEEF, 4'h5, 4'hF);
        tick();
        check_eq("reset_rdata_a", 36'(rdata[0]), 36'h0);
        check_eq("reset_rpar_a", 36'(rpar[0]), 36'h0);
        reset = 1'b0;
        rd(0, 15'h0020, "a_post_reset", 32'h1234_5678, 4'hA);
        tick();
        tick();
        check_eq("a_hold", {rpar[0], rdata[0]}, {4'hA, 32'h1234_5678});

        wr(2, 15'h0000, 32'hDDCC_BBAA, 4'hF, 4'hF);
        tick();
        rd(3, 15'h0018, "mix_b_w9_lane3", 32'h0000_00DD, 4'h1);
        tick();
        rd(2, 15'h0010, "mix_a_r18_half1", 32'h0000_DDCC, 4'h3);
        rd(3, 15'h0008, "mix_b_w9_lane1", 32'h0000_00BB, 4'h1);
        tick();
        wr(3, 15'h0008, 32'h0000_015A, 4'h0, 4'b0001);
        tick();
        rd(2, 15'h0000, "mix_a_r18_half0", 32'h0000_5AAA, 4'h1);
        tick();
        wr(3, 15'h0000, 32'h0000_0011, 4'h1, 4'b1110);
        tick();
        rd(3, 15'h0000, "mix_b_be0_gate", 32'h0000_00AA, 4'h1);
        tick();

        check_eq("sb_drain", 36'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 36'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
